acp_ram_arbiter: RTL and testbench

ACP_RAM_ARBITER -- requirements
Module: acp_ram_arbiter

---
 rtl/acp_ram_arbiter.sv | 172 +++++++++++++++++
 tb/tb_acp_ram_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/acp_ram_arbiter.sv
// acp_ram_arbiter
// Shares one single-port 32-word scratch RAM between the L1 requesters
// (index 0 dcache, 1 dmmu, 2 icache, 3 immu). Requests are granted
// round-robin. A requester can hold the grant across beats with req_lock.
// Accepted beats are registered onto the RAM port one cycle after transfer.
// Read data is returned RAM_LATENCY+1 cycles after transfer, steered by a
// requester-ID shift register.
//
// Ports
//   clk, rst            single clock, synchronous active-high reset
//   req_valid/lock/we   per-requester request, lock-after-beat, write flag
//   req_be/addr/wdata   per-requester byte enables, byte address, write data
//   req_ready           one-hot accept (combinational)
//   rsp_valid           one-hot read-data strobe
//   rsp_rdata, rsp_err  shared read data and access-error flag
//   ram_en/we/addr/wdata/rdata   registered RAM port (word address [6:2])
//
// Optional feature: define ACP_ARB_ADDR_CHECK_EN to reject addresses outside
// 0x00030000..0x0003007F. Rejected beats are accepted but never reach the
// RAM. Rejected reads answer with rsp_err=1 and zero data.
module acp_ram_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int RAM_LATENCY = 1,
  parameter int ADDR_W      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [4*NUM_REQ-1:0]      req_be,
  input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
  input  logic [32*NUM_REQ-1:0]     req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [31:0]               rsp_rdata,
  output logic                      rsp_err,
  output logic                      ram_en,
  output logic [3:0]                ram_we,
  output logic [4:0]                ram_addr,
  output logic [31:0]               ram_wdata,
  input  logic [31:0]               ram_rdata
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int DEPTH = RAM_LATENCY + 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   ptr, owner, gidx, cidx;
  logic               xfer;

  logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
  logic [3:0]         be_arr    [NUM_REQ];
  logic [31:0]        wdata_arr [NUM_REQ];

  logic [ADDR_W-1:0]  sel_addr;
  logic [3:0]         sel_be;
  logic [31:0]        sel_wdata;
  logic               sel_we;
  logic               addr_ok;
  logic               unused_addr;

  logic [DEPTH-1:0]   pipe_v;
  logic [DEPTH-1:0]   pipe_err;
  logic [IDX_W-1:0]   pipe_id [DEPTH];

  // Unpack the flat request buses so the granted requester can be muxed by index
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
    assign be_arr[g]    = req_be[g*4 +: 4];
    assign wdata_arr[g] = req_wdata[g*32 +: 32];
  end

  assign sel_addr  = addr_arr[gidx];
  assign sel_be    = be_arr[gidx];
  assign sel_wdata = wdata_arr[gidx];
  assign sel_we    = req_we[gidx];

`ifdef ACP_ARB_ADDR_CHECK_EN
  localparam logic [ADDR_W-1:0] WIN_BASE = ADDR_W'(32'h0003_0000);
  // The window is 128 bytes and aligned, so only the bits above [6:0] matter
  assign addr_ok     = (sel_addr[ADDR_W-1:7] == WIN_BASE[ADDR_W-1:7]);
  assign unused_addr = ^sel_addr[1:0];
`else
  assign addr_ok     = 1'b1;
  assign unused_addr = ^{sel_addr[ADDR_W-1:7], sel_addr[1:0]};
`endif

  // State register. ptr records the last granted index. owner is captured on
  // every IDLE grant, so it is already correct if that beat takes the lock.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= IDX_W'(NUM_REQ - 1);
      owner <= '0;
    end else begin
      state <= state_nxt;
      if (xfer) begin
        ptr <= gidx;
        if (state == IDLE) owner <= gidx;
      end
    end
  end

  // Next state. Any transfer decides lock status from its own req_lock bit.
  // Only the owner can transfer while LOCKED, so no owner check is needed here.
  always_comb begin
    state_nxt = state;
    if (xfer) state_nxt = req_lock[gidx] ? LOCKED : IDLE;
  end

  // Grant. LOCKED serves only the owner. IDLE scans from ptr+1 with wrap and
  // takes the first valid requester.
  always_comb begin
    req_ready = '0;
    gidx      = '0;
    cidx      = '0;
    xfer      = 1'b0;
    if (state == LOCKED) begin
      if (req_valid[owner]) begin
        req_ready[owner] = 1'b1;
        gidx             = owner;
        xfer             = 1'b1;
      end
    end else begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        cidx = IDX_W'((int'(ptr) + k) % NUM_REQ);
        if (!xfer && req_valid[cidx]) begin
          req_ready[cidx] = 1'b1;
          gidx            = cidx;
          xfer            = 1'b1;
        end
      end
    end
  end

  // RAM port and response tracking. Stage 0 captures the beat at transfer.
  // The last stage lines up with ram_rdata.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_en    <= 1'b0;
      ram_we    <= 4'h0;
      ram_addr  <= 5'd0;
      ram_wdata <= 32'h0;
      pipe_v    <= '0;
      pipe_err  <= '0;
      for (int s = 0; s < DEPTH; s++) pipe_id[s] <= '0;
    end else begin
      ram_en <= xfer && addr_ok;
      ram_we <= (xfer && addr_ok && sel_we) ? sel_be : 4'h0;
      if (xfer) begin
        ram_addr  <= sel_addr[6:2];
        ram_wdata <= sel_wdata;
      end
      pipe_v[0]   <= xfer && !sel_we;
      pipe_err[0] <= !addr_ok;
      pipe_id[0]  <= gidx;
      for (int s = 1; s < DEPTH; s++) begin
        pipe_v[s]   <= pipe_v[s-1];
        pipe_err[s] <= pipe_err[s-1];
        pipe_id[s]  <= pipe_id[s-1];
      end
    end
  end

  assign rsp_valid = pipe_v[DEPTH-1] ? (NUM_REQ'(1) << pipe_id[DEPTH-1]) : '0;
  assign rsp_err   = pipe_v[DEPTH-1] & pipe_err[DEPTH-1];
  assign rsp_rdata = rsp_err ? 32'h0 : ram_rdata;

endmodule

// File: tb/tb_acp_ram_arbiter.sv
// tb_acp_ram_arbiter
// Directed bench for acp_ram_arbiter. The main instance uses RAM_LATENCY=1
// and runs against a 32-word byte-writable RAM model. That RAM reloads the
// pattern 0xA0000000|word on reset. A second instance uses RAM_LATENCY=3 and
// drives address-tagged read data (0xC0000000|word) to check sustained reads.
// Inputs change 1 time unit after the rising edge. Outputs are sampled 2 time
// units after the rising edge.
module tb_acp_ram_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req_valid = '0, req_lock = '0, req_we = '0;
  logic [15:0]  req_be = '0;
  logic [127:0] req_addr = '0, req_wdata = '0;
  logic [3:0]   req_ready, rsp_valid;
  logic [31:0]  rsp_rdata, ram_wdata, ram_rdata;
  logic         rsp_err, ram_en;
  logic [3:0]   ram_we;
  logic [4:0]   ram_addr;

  logic [3:0]   v3 = '0;
  logic [127:0] addr3 = '0;
  logic [3:0]   ready3, rsp_valid3, unused_we3;
  logic [31:0]  rdata3, ram_rdata3, unused_wdata3;
  logic         err3, ram_en3;
  logic [4:0]   ram_addr3;

  logic [31:0]  mem [32];
  logic [31:0]  rd_q;
  logic [31:0]  p0, p1, p2;

  logic [31:0]  nxt_addr [4];
  logic [3:0]   nxt_be [4];
  logic [31:0]  nxt_wdata [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  acp_ram_arbiter #(.NUM_REQ(4), .RAM_LATENCY(1), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_lock(req_lock), .req_we(req_we),
    .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  acp_ram_arbiter #(.NUM_REQ(4), .RAM_LATENCY(3), .ADDR_W(32)) dut3 (
    .clk(clk), .rst(rst),
    .req_valid(v3), .req_lock(4'h0), .req_we(4'h0),
    .req_be(16'h0), .req_addr(addr3), .req_wdata(128'h0),
    .req_ready(ready3), .rsp_valid(rsp_valid3), .rsp_rdata(rdata3),
    .rsp_err(err3), .ram_en(ram_en3), .ram_we(unused_we3), .ram_addr(ram_addr3),
    .ram_wdata(unused_wdata3), .ram_rdata(ram_rdata3)
  );

  // One-cycle RAM with per-byte writes. Reset reloads a known pattern.
  always @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < 32; w++) mem[w] <= 32'hA000_0000 | 32'(w);
      rd_q <= 32'h0;
    end else if (ram_en) begin
      rd_q <= mem[ram_addr];
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
    end
  end
  assign ram_rdata = rd_q;

  // Three-cycle read pipe. Data carries the word index so the bench can check ordering.
  always @(posedge clk) begin
    if (rst) begin
      p0 <= 32'h0; p1 <= 32'h0; p2 <= 32'h0;
    end else begin
      p0 <= 32'hC000_0000 | 32'(ram_addr3);
      p1 <= p0;
      p2 <= p1;
    end
  end
  assign ram_rdata3 = p2;

  task automatic applyStimulus(input logic [3:0] v, input logic [3:0] lk, input logic [3:0] w);
    @(posedge clk);
    #1;
    req_valid = v;
    req_lock  = lk;
    req_we    = w;
    for (int i = 0; i < 4; i++) begin
      req_addr[i*32 +: 32]  = nxt_addr[i];
      req_be[i*4 +: 4]      = nxt_be[i];
      req_wdata[i*32 +: 32] = nxt_wdata[i];
    end
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic setDefaults();
    for (int i = 0; i < 4; i++) begin
      nxt_addr[i]  = 32'h0003_0000 + 32'(4 * (8 + i));
      nxt_be[i]    = 4'hF;
      nxt_wdata[i] = 32'h0;
    end
  endtask

  initial begin
    setDefaults();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    $display("[TB] reset state");
    checkOutput("rst_ram_en",    32'(ram_en),    32'h0);
    checkOutput("rst_ram_we",    32'(ram_we),    32'h0);
    checkOutput("rst_ram_addr",  32'(ram_addr),  32'h0);
    checkOutput("rst_ram_wdata", ram_wdata,      32'h0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("rst_rsp_err",   32'(rsp_err),   32'h0);
    checkOutput("rst_ready",     32'(req_ready), 32'h0);

    $display("[TB] round-robin reads from all four requesters");
    applyStimulus(4'b1111, 4'b0000, 4'b0000);
    checkOutput("rr_ready_c0", 32'(req_ready), 32'h1);
    applyStimulus(4'b1111, 4'b0000, 4'b0000);
    checkOutput("rr_ready_c1", 32'(req_ready), 32'h2);
    checkOutput("rr_ram_en_c1", 32'(ram_en), 32'h1);
    checkOutput("rr_ram_addr_c1", 32'(ram_addr), 32'd8);
    checkOutput("rr_ram_we_c1", 32'(ram_we), 32'h0);
    applyStimulus(4'b1111, 4'b0000, 4'b0000);
    checkOutput("rr_ready_c2", 32'(req_ready), 32'h4);
    checkOutput("rr_rsp_c2", 32'(rsp_valid), 32'h1);
    checkOutput("rr_data_c2", rsp_rdata, 32'hA000_0008);
    applyStimulus(4'b1111, 4'b0000, 4'b0000);
    checkOutput("rr_ready_c3", 32'(req_ready), 32'h8);
    checkOutput("rr_rsp_c3", 32'(rsp_valid), 32'h2);
    checkOutput("rr_data_c3", rsp_rdata, 32'hA000_0009);
    applyStimulus(4'b1111, 4'b0000, 4'b0000);
    checkOutput("rr_ready_wrap_c4", 32'(req_ready), 32'h1);
    checkOutput("rr_rsp_c4", 32'(rsp_valid), 32'h4);
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    checkOutput("rr_ready_c5", 32'(req_ready), 32'h0);
    checkOutput("rr_rsp_c5", 32'(rsp_valid), 32'h8);
    checkOutput("rr_data_c5", rsp_rdata, 32'hA000_000B);
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    checkOutput("rr_rsp_c6", 32'(rsp_valid), 32'h1);
    checkOutput("rr_err_c6", 32'(rsp_err), 32'h0);
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    checkOutput("rr_rsp_c7", 32'(rsp_valid), 32'h0);
    checkOutput("rr_idle_ram_en_c7", 32'(ram_en), 32'h0);

    $display("[TB] write then read back");
    nxt_addr[2]  = 32'h0003_0010;
    nxt_wdata[2] = 32'hDEAD_BEEF;
    nxt_addr[0]  = 32'h0003_0010;
    applyStimulus(4'b0100, 4'b0000, 4'b0100);
    checkOutput("wr_ready_c0", 32'(req_ready), 32'h4);
    applyStimulus(4'b0001, 4'b0000, 4'b0000);
    checkOutput("wr_ready_c1", 32'(req_ready), 32'h1);
    checkOutput("wr_ram_en", 32'(ram_en), 32'h1);
    checkOutput("wr_ram_we", 32'(ram_we), 32'hF);
    checkOutput("wr_ram_addr", 32'(ram_addr), 32'd4);
    checkOutput("wr_ram_wdata", ram_wdata, 32'hDEAD_BEEF);
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    checkOutput("wr_no_rsp", 32'(rsp_valid), 32'h0);
    checkOutput("rd_ram_we", 32'(ram_we), 32'h0);
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    checkOutput("rd_rsp", 32'(rsp_valid), 32'h1);
    checkOutput("rd_data", rsp_rdata, 32'hDEAD_BEEF);
    setDefaults();

    $display("[TB] lock held by requester 1");
    applyStimulus(4'b0010, 4'b0010, 4'b0000);
    checkOutput("lk_ready_c0", 32'(req_ready), 32'h2);
    applyStimulus(4'b1101, 4'b0000, 4'b0000);
    checkOutput("lk_ready_c1", 32'(req_ready), 32'h0);
    applyStimulus(4'b1101, 4'b0000, 4'b0000);
    checkOutput("lk_ready_c2", 32'(req_ready), 32'h0);
    checkOutput("lk_rsp_c2", 32'(rsp_valid), 32'h2);
    checkOutput("lk_data_c2", rsp_rdata, 32'hA000_0009);
    applyStimulus(4'b1101, 4'b0000, 4'b0000);
    checkOutput("lk_ready_c3", 32'(req_ready), 32'h0);
    checkOutput("lk_ram_en_c3", 32'(ram_en), 32'h0);
    nxt_wdata[1] = 32'h1234_5678;
    applyStimulus(4'b1111, 4'b0000, 4'b0010);
    checkOutput("lk_release_ready", 32'(req_ready), 32'h2);
    applyStimulus(4'b1101, 4'b0000, 4'b0000);
    checkOutput("lk_next_grant", 32'(req_ready), 32'h4);
    checkOutput("lk_wr_ram_we", 32'(ram_we), 32'hF);
    checkOutput("lk_wr_wdata", ram_wdata, 32'h1234_5678);
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    checkOutput("lk_rsp_after", 32'(rsp_valid), 32'h4);
    checkOutput("lk_data_after", rsp_rdata, 32'hA000_000A);
    setDefaults();

    $display("[TB] reset with a read in flight and a lock held");
    applyStimulus(4'b1000, 4'b1000, 4'b0000);
    checkOutput("mr_ready_c0", 32'(req_ready), 32'h8);
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    rst = 1'b1;
    checkOutput("mr_ram_en_c1", 32'(ram_en), 32'h1);
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    rst = 1'b0;
    checkOutput("mr_rsp_dropped", 32'(rsp_valid), 32'h0);
    checkOutput("mr_ram_en_c2", 32'(ram_en), 32'h0);
    applyStimulus(4'b1111, 4'b0000, 4'b0000);
    checkOutput("mr_grant_idx0", 32'(req_ready), 32'h1);
    checkOutput("mr_rsp_c3", 32'(rsp_valid), 32'h0);
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    checkOutput("mr_rsp_c5", 32'(rsp_valid), 32'h1);
    checkOutput("mr_data_c5", rsp_rdata, 32'hA000_0008);

    $display("[TB] out-of-window read from requester 3");
    nxt_addr[3] = 32'h0003_0080;
    applyStimulus(4'b1000, 4'b0000, 4'b0000);
    checkOutput("oow_ready", 32'(req_ready), 32'h8);
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
`ifdef ACP_ARB_ADDR_CHECK_EN
    checkOutput("oow_ram_en", 32'(ram_en), 32'h0);
`else
    checkOutput("oow_ram_en", 32'(ram_en), 32'h1);
    checkOutput("oow_ram_addr", 32'(ram_addr), 32'h0);
`endif
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    checkOutput("oow_rsp", 32'(rsp_valid), 32'h8);
`ifdef ACP_ARB_ADDR_CHECK_EN
    checkOutput("oow_err", 32'(rsp_err), 32'h1);
    checkOutput("oow_data", rsp_rdata, 32'h0);
`else
    checkOutput("oow_err", 32'(rsp_err), 32'h0);
    checkOutput("oow_data", rsp_rdata, 32'hA000_0000);
`endif
    setDefaults();

    $display("[TB] back-to-back reads at RAM_LATENCY=3");
    for (int k = 0; k <= 12; k++) begin
      @(posedge clk);
      #1;
      v3 = (k < 8) ? 4'b0001 : 4'b0000;
      if (k < 8) addr3[31:0] = 32'h0003_0000 + 32'(4 * k);
      #1;
      if (k < 8) checkOutput($sformatf("b2b_ready_%0d", k), 32'(ready3), 32'h1);
      if (k == 1) checkOutput("b2b_ram_en", 32'(ram_en3), 32'h1);
      if (k >= 4 && k < 12) begin
        checkOutput($sformatf("b2b_rsp_%0d", k), 32'(rsp_valid3), 32'h1);
        checkOutput($sformatf("b2b_data_%0d", k), rdata3, 32'hC000_0000 + 32'(k - 4));
      end
      if (k == 5) checkOutput("b2b_err", 32'(err3), 32'h0);
      if (k == 12) checkOutput("b2b_rsp_end", 32'(rsp_valid3), 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
